bus_master_interface: RTL and testbench

//   Single bus initiator that turns a client request/response handshake into
//   the system bus cycle that memory-mapped devices answer: addr/data/rd/wr/mask
//   out, tri-state data_bus, fc_bus (function complete) back from the target.

---
 rtl/bus_master_interface.sv | 157 +++++++++++++++
 tb/tb_bus_master_interface.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_interface.sv
// Single-initiator bus master: converts a client request/response handshake into
// a strobed device-bus cycle with alignment checking and a no-progress timeout.
module bus_master_interface #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] addr_bus,
  inout  wire  [31:0] data_bus,
  output logic        rd_bus,
  output logic        wr_bus,
  output logic [3:0]  data_mask_bus,
  input  logic        fc_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RELEASE,
    S_RESP
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic fc_done;
  logic req_legal;
  logic timed_out;
  logic busy;

  // Only a clean 1 counts as completion; a floating or unknown fc is "not done".
  assign fc_done = (fc_bus === 1'b1);

  assign req_legal = (req_mask == 4'b0001) ||
                     ((req_mask == 4'b0011) && !req_addr[0]) ||
                     ((req_mask == 4'b1111) && (req_addr[1:0] == 2'b00));

  assign busy      = (state_q == S_READ) || (state_q == S_WRITE) || (state_q == S_RELEASE);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          mask_d  = req_mask;
          wdata_d = req_wdata;
          err_d   = 1'b0;
          if (!req_legal) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_write) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (fc_done) begin
          rdata_d = data_bus;
          state_d = S_RESP;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WRITE: begin
        if (fc_done) begin
          state_d = S_RELEASE;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RELEASE: begin
        // Wait for the target to drop fc before reporting, so the next cycle starts clean.
        if (!fc_done) begin
          state_d = S_RESP;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from the state register, so reset drops them at once.
  assign req_ready     = (state_q == S_IDLE);
  assign rsp_valid     = (state_q == S_RESP);
  assign rd_bus        = (state_q == S_READ);
  assign wr_bus        = (state_q == S_WRITE);
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;
  assign addr_bus      = addr_q;
  assign data_mask_bus = mask_q;
  assign data_bus      = wr_bus ? wdata_q : 32'bz;

endmodule

// File: tb/tb_bus_master_interface.sv
// Directed bench for bus_master_interface with a small memory-mapped target at
// 0x1000-0x10FF: fc combinational on reads, fc from a DONE state on writes.
module tb_bus_master_interface;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] addr_bus;
  wire  [31:0] data_bus;
  logic        rd_bus;
  logic        wr_bus;
  logic [3:0]  data_mask_bus;
  wire         fc_bus;

  int tests_run = 0;
  int tests_failed = 0;

  bus_master_interface #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_mask(req_mask),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .addr_bus(addr_bus),
    .data_bus(data_bus),
    .rd_bus(rd_bus),
    .wr_bus(wr_bus),
    .data_mask_bus(data_mask_bus),
    .fc_bus(fc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Target model
  logic [31:0] mem [0:3];
  logic        done_q;
  logic        mapped;
  logic [31:0] lane_mask;
  assign mapped    = (addr_bus[31:8] == 24'h000010);
  assign lane_mask = {{8{data_mask_bus[3]}}, {8{data_mask_bus[2]}},
                      {8{data_mask_bus[1]}}, {8{data_mask_bus[0]}}};
  assign fc_bus    = (mapped && (rd_bus || done_q)) ? 1'b1 : 1'bz;
  assign data_bus  = (mapped && rd_bus) ? mem[addr_bus[3:2]] : 32'bz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else if (!done_q && wr_bus && mapped) begin
      done_q <= 1'b1;
      mem[addr_bus[3:2]] <= (mem[addr_bus[3:2]] & ~lane_mask) | (data_bus & lane_mask);
    end else if (done_q && !wr_bus && !rd_bus) begin
      done_q <= 1'b0;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    tests_run++; if (rd_bus !== 1'b0 || wr_bus !== 1'b0) begin tests_failed++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", rd_bus, wr_bus); end
    tests_run++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp: got valid=%b err=%b want 0 0", rsp_valid, rsp_err); end
    tests_run++; if (rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    tests_run++; if (addr_bus !== 32'h0 || data_mask_bus !== 4'h0) begin tests_failed++; $display("FAIL reset_addr_mask: got %h/%b want 0/0", addr_bus, data_mask_bus); end
    tests_run++; if (!(data_bus === 32'bz || data_bus === 32'h0)) begin tests_failed++; $display("FAIL reset_data_bus: got %h want z", data_bus); end
    $display("[TB] reset done");
  endtask

  task automatic test_read_comb();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1004; req_mask = 4'b0001; req_wdata = 32'hFFFF_FFFF;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rd_ready: got %b want 1", req_ready); end
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    tests_run++; if (rd_bus !== 1'b1 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_e0: got rd=%b valid=%b want 1 0", rd_bus, rsp_valid); end
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL rd_rsp: got valid=%b err=%b want 1 0", rsp_valid, rsp_err); end
    tests_run++; if (rsp_rdata !== 32'h0000_00A5) begin tests_failed++; $display("FAIL rd_data: got %h want 000000a5", rsp_rdata); end
    tests_run++; if (rd_bus !== 1'b0 || req_ready !== 1'b0) begin tests_failed++; $display("FAIL rd_e1: got rd=%b ready=%b want 0 0", rd_bus, req_ready); end
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL rd_e2: got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
    tests_run++; if (addr_bus !== 32'h1004 || data_mask_bus !== 4'b0001 || rsp_rdata !== 32'hA5) begin tests_failed++; $display("FAIL rd_hold: got addr=%h mask=%b rdata=%h want 1004 0001 a5", addr_bus, data_mask_bus, rsp_rdata); end
    $display("[TB] read  addr=%h mask=%b -> rdata=%h err=%b", 32'h1004, 4'b0001, rsp_rdata, rsp_err);
  endtask

  task automatic test_write_done();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000; req_mask = 4'b0001; req_wdata = 32'h0000_000F;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    tests_run++; if (wr_bus !== 1'b1 || data_bus !== 32'h0000_000F) begin tests_failed++; $display("FAIL wr_e0: got wr=%b data=%h want 1 0000000f", wr_bus, data_bus); end
    @(negedge clk);
    tests_run++; if (wr_bus !== 1'b1) begin tests_failed++; $display("FAIL wr_e1: got wr=%b want 1", wr_bus); end
    @(negedge clk);
    tests_run++; if (wr_bus !== 1'b0 || !(data_bus === 32'bz || data_bus === 32'h0)) begin tests_failed++; $display("FAIL wr_e2: got wr=%b data=%h want 0 z", wr_bus, data_bus); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL wr_e2_valid: got %b want 0", rsp_valid); end
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0 || addr_bus !== 32'h1000) begin tests_failed++; $display("FAIL wr_e3: got valid=%b addr=%h want 0 1000", rsp_valid, addr_bus); end
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL wr_rsp: got valid=%b err=%b want 1 0", rsp_valid, rsp_err); end
    tests_run++; if (mem[0] !== 32'h1122_330F) begin tests_failed++; $display("FAIL wr_target: got %h want 1122330f", mem[0]); end
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL wr_e5: got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
    $display("[TB] write addr=%h wdata=%h mask=%b -> target=%h", 32'h1000, 32'h0F, 4'b0001, mem[0]);
  endtask

  task automatic test_timeout();
    int rd_cycles = 0;
    int lat = -1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h9000; req_mask = 4'b1111; req_wdata = '0;
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rd_bus === 1'b1) rd_cycles++;
      if (rsp_valid === 1'b1) begin lat = i; break; end
    end
    tests_run++; if (lat != 8) begin tests_failed++; $display("FAIL to_latency: got %0d want 8", lat); end
    tests_run++; if (rd_cycles != 8) begin tests_failed++; $display("FAIL to_rd_cycles: got %0d want 8", rd_cycles); end
    tests_run++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || rd_bus !== 1'b0) begin tests_failed++; $display("FAIL to_rsp: got err=%b rdata=%h rd=%b want 1 0 0", rsp_err, rsp_rdata, rd_bus); end
    @(negedge clk);
    $display("[TB] read  addr=%h unmapped -> err=%b rdata=%h after %0d cycles", 32'h9000, rsp_err, rsp_rdata, lat);
  endtask

  task automatic test_misaligned();
    logic [31:0] v_addr  [0:2];
    logic [3:0]  v_mask  [0:2];
    logic        v_write [0:2];
    v_addr[0] = 32'h1002; v_mask[0] = 4'b0101; v_write[0] = 1'b0;
    v_addr[1] = 32'h1002; v_mask[1] = 4'b1111; v_write[1] = 1'b1;
    v_addr[2] = 32'h1001; v_mask[2] = 4'b0011; v_write[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_write = v_write[k]; req_addr = v_addr[k]; req_mask = v_mask[k]; req_wdata = 32'h5A5A_5A5A;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin tests_failed++; $display("FAIL mis%0d_rsp: got valid=%b err=%b want 1 1", k, rsp_valid, rsp_err); end
      tests_run++; if (rd_bus !== 1'b0 || wr_bus !== 1'b0 || !(data_bus === 32'bz || data_bus === 32'h0)) begin tests_failed++; $display("FAIL mis%0d_bus: got rd=%b wr=%b data=%h want 0 0 z", k, rd_bus, wr_bus, data_bus); end
      @(negedge clk);
      tests_run++; if (rsp_valid !== 1'b0 || rd_bus !== 1'b0 || wr_bus !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL mis%0d_after: got valid=%b rd=%b wr=%b ready=%b want 0 0 0 1", k, rsp_valid, rd_bus, wr_bus, req_ready); end
      $display("[TB] %s addr=%h mask=%b -> err=%b", v_write[k] ? "write" : "read ", v_addr[k], v_mask[k], rsp_err);
    end
  endtask

  task automatic test_reset_mid_write();
    int seen = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h9000; req_mask = 4'b1111; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    tests_run++; if (wr_bus !== 1'b1) begin tests_failed++; $display("FAIL rstw_wr_before: got %b want 1", wr_bus); end
    #1 rst = 1'b1;
    #1;
    tests_run++; if (wr_bus !== 1'b0 || !(data_bus === 32'bz || data_bus === 32'h0)) begin tests_failed++; $display("FAIL rstw_async: got wr=%b data=%h want 0 z", wr_bus, data_bus); end
    tests_run++; if (addr_bus !== 32'h0 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rstw_state: got addr=%h valid=%b want 0 0", addr_bus, rsp_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rstw_ready: got %b want 1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL rstw_no_rsp: got %0d pulses want 0", seen); end
    $display("[TB] write addr=%h aborted by reset -> rsp pulses=%0d", 32'h9000, seen);
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int rsps = 0;
    int first_rsp_cyc = -1;
    int second_acc_cyc = -1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1008; req_mask = 4'b0011; req_wdata = 32'h0000_1234;
    for (int c = 0; c < 40 && rsps < 2; c++) begin
      if (req_ready === 1'b1 && req_valid) begin
        accepts++;
        if (accepts == 2) second_acc_cyc = c;
      end
      @(posedge clk); @(negedge clk);
      if (accepts == 1) begin req_write = 1'b0; req_wdata = 32'hFFFF_FFFF; end
      if (accepts == 2) req_valid = 1'b0;
      if (rsp_valid === 1'b1) begin
        rsps++;
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_in_rsp%0d: got %b want 0", rsps, req_ready); end
        tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_err%0d: got %b want 0", rsps, rsp_err); end
        if (rsps == 1) begin
          first_rsp_cyc = c;
          $display("[TB] write addr=%h wdata=%h mask=%b -> err=%b", 32'h1008, 32'h1234, 4'b0011, rsp_err);
        end else begin
          tests_run++; if (rsp_rdata !== 32'hDEAD_1234) begin tests_failed++; $display("FAIL b2b_rdata: got %h want dead1234", rsp_rdata); end
          $display("[TB] read  addr=%h mask=%b -> rdata=%h err=%b", 32'h1008, 4'b0011, rsp_rdata, rsp_err);
        end
      end
    end
    req_valid = 1'b0;
    tests_run++; if (accepts != 2 || rsps != 2) begin tests_failed++; $display("FAIL b2b_counts: got acc=%0d rsp=%0d want 2 2", accepts, rsps); end
    tests_run++; if (first_rsp_cyc < 0 || second_acc_cyc != first_rsp_cyc + 2) begin tests_failed++; $display("FAIL b2b_spacing: got rsp@%0d acc2@%0d want acc2=rsp+2", first_rsp_cyc, second_acc_cyc); end
    @(negedge clk);
  endtask

  initial begin
    mem[0] = 32'h1122_3344;
    mem[1] = 32'h0000_00A5;
    mem[2] = 32'hDEAD_BEEF;
    mem[3] = 32'h0;
    test_reset();
    test_read_comb();
    test_write_done();
    test_timeout();
    test_misaligned();
    test_reset_mid_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
